sync_fifo_wr_arb: RTL
=====================

// Module: sync_fifo_wr_arb
// PURPOSE
// - Round-robin write arbiter sharing one sync FIFO write port between NREQ requesters.
// - Sits between the requesters and the FIFO write side. Drives fifo_wen/fifo_data_in and
//   back-pressures each requester with a valid/ready handshake gated by fifo_full.
// - A grant is locked for a burst of up to BURST_MAX beats so a requester's words stay contiguous.
// PARAMETERS
// - NREQ       4           number of requesters, >=2, need not be a power of 2
// - BURST_MAX  4           max beats per grant before forced rotation, >=1
// - T          logic [7:0] payload type, identical to the FIFO's T
// PORTS
// - clk           in   1             clock
// - rst_n         in   1             asynchronous active-low reset
// - req_valid     in   NREQ          per-requester write request
// - req_data      in   NREQ x T      per-requester payload (unpacked array)
// - req_ready     out  NREQ          beat accepted when req_valid[i] & req_ready[i]
// - fifo_full     in   1             FIFO full flag
// - fifo_wen      out  1             FIFO write enable
// - fifo_data_in  out  T             FIFO write data
// - grant_id      out  $clog2(NREQ)  current owner index (valid while busy)
// - busy          out  1             1 while a grant is locked
// BEHAVIOUR
// - Reset: all state is cleared asynchronously. State IDLE, rr_ptr=0, beat_cnt=0, grant_id=0, busy=0.
//   req_ready and fifo_wen are forced to 0 while rst_n=0. Reset mid-burst drops the lock immediately
//   and the aborted burst is not resumed.
// - The data path is combinational (zero latency): fifo_wen = |(req_valid & req_ready).
//   fifo_data_in = req_data[winner]. At most one req_ready bit is high in any cycle.
// - FSM has 2 states.
// - IDLE:
//   - winner = first i with req_valid[i], searching from rr_ptr upward and wrapping modulo NREQ.
//   - req_ready[winner] = !fifo_full.
//   - If any valid is present, go to LOCKED next edge with owner=winner. This holds even when
//     fifo_full=1, so the grant is held while stalled.
//   - If the beat was accepted, beat_cnt=1; otherwise beat_cnt=0.
//   - If accepted and BURST_MAX==1: stay IDLE and set rr_ptr=winner+1 (wrapped).
// - LOCKED:
//   - Only the owner may win. req_ready[owner] = !fifo_full.
//   - Each accepted beat increments beat_cnt.
//   - Release to IDLE at the next edge when either:
//     (a) an accepted beat makes beat_cnt==BURST_MAX, or
//     (b) req_valid[owner]==0.
//   - On release: rr_ptr=owner+1 (wrapped; non-pow2 NREQ wraps NREQ-1 -> 0) and beat_cnt=0.
//   - Case (b) costs exactly one idle cycle; no other requester is served in that cycle.
// - fifo_full=1: no ready is asserted and fifo_wen=0. The lock and beat_cnt are held.
//   Valid may be held indefinitely.
// - busy=(state==LOCKED). grant_id=owner while LOCKED, otherwise holds its last value.
// - Requesters must hold req_valid/req_data stable until accepted. This is not checked.
// - beat_cnt width is $clog2(BURST_MAX+1). rr_ptr width is $clog2(NREQ).
// CONFIGURATION
// - SYNC_FIFO_WR_ARB_STATS_EN defined:
//   - Adds output port stat_beats [NREQ][15:0].
//   - Per-requester count of accepted beats, saturating at 16'hFFFF, cleared to 0 by rst_n.
//   - Also adds output stat_stall_cyc [15:0]: saturating count of cycles with any req_valid=1
//     and fifo_full=1.
// - Not defined: these ports and counters do not exist, and all other behaviour is identical.
// TESTING
// - Reset, then req_valid=4'b1111, fifo_full=0 held -> grants in order 0,1,2,3,0, with 4
//   consecutive fifo_wen beats each (BURST_MAX=4).
// - Req 2 alone valid for 2 beats, then drops -> 2 writes, 1 idle cycle, then rr_ptr=3 and busy=0.
// - fifo_full=1 for 5 cycles mid-burst of req 1 -> fifo_wen=0 and req_ready=0; grant_id stays 1.
//   After full deasserts, the remaining beats complete.
// - NREQ=3, owner 2 completes a burst -> rr_ptr wraps to 0; next grant goes to 0 if valid.
// - Assert rst_n=0 during beat 2 of a burst -> req_ready=0 and fifo_wen=0 immediately.
//   After release: busy=0, rr_ptr=0.
// - STATS_EN: push 3 beats from req 0 and 1 from req 3 -> stat_beats[0]=3, stat_beats[3]=1.
//   Preload near saturation -> counter holds at 16'hFFFF.

Source files
------------

// File: rtl/sync_fifo_wr_arb.sv
// sync_fifo_wr_arb: round-robin arbiter sharing one sync FIFO write port
// between NREQ requesters. A grant is locked for up to BURST_MAX beats so a
// requester's words land contiguously in the FIFO.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid/ready   per-requester valid/ready handshake (at most one ready high)
//   req_data          per-requester payload (unpacked array of T)
//   fifo_full         FIFO full flag; stalls all handshakes, holds the lock
//   fifo_wen          FIFO write enable (combinational, zero latency)
//   fifo_data_in      FIFO write data (combinational mux of the winner)
//   grant_id          current owner while busy, else last owner
//   busy              1 while a grant is locked
//
// Optional build macro SYNC_FIFO_WR_ARB_STATS_EN adds:
//   stat_beats[NREQ]  saturating per-requester accepted beat counters
//   stat_stall_cyc    saturating count of cycles with any valid while full
module sync_fifo_wr_arb #(
   parameter int unsigned NREQ      = 4,
   parameter int unsigned BURST_MAX = 4,
   parameter type         T         = logic [7:0]
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req_valid,
   input  T                        req_data [NREQ],
   output logic [NREQ-1:0]         req_ready,
   input  logic                    fifo_full,
   output logic                    fifo_wen,
   output T                        fifo_data_in,
   output logic [$clog2(NREQ)-1:0] grant_id,
   output logic                    busy
`ifdef SYNC_FIFO_WR_ARB_STATS_EN
   ,
   output logic [15:0]             stat_beats [NREQ],
   output logic [15:0]             stat_stall_cyc
`endif
);

   localparam int unsigned IDW = $clog2(NREQ);
   localparam int unsigned CW  = $clog2(BURST_MAX + 1);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e          state_q, state_d;
   logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
   logic [CW-1:0]   beat_cnt_q, beat_cnt_d;
   logic [IDW-1:0]  grant_id_q, grant_id_d;

   logic            found;
   logic [IDW-1:0]  winner;
   logic [IDW-1:0]  sel;
   logic [NREQ-1:0] ready_c;
   logic            accept;
   int unsigned     idx;

   // Index increment that wraps NREQ-1 -> 0 for any NREQ.
   function automatic logic [IDW-1:0] inc_wrap(input logic [IDW-1:0] x);
      if (x == IDW'(NREQ - 1)) return '0;
      return x + IDW'(1);
   endfunction

   // Round-robin search from rr_ptr, wrapping modulo NREQ.
   always_comb begin
      found  = 1'b0;
      winner = rr_ptr_q;
      idx    = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(rr_ptr_q) + k) % NREQ;
         if (!found && req_valid[IDW'(idx)]) begin
            found  = 1'b1;
            winner = IDW'(idx);
         end
      end
   end

   // Combinational handshake and data path; reset forces ready low.
   always_comb begin
      sel     = (state_q == LOCKED) ? grant_id_q : winner;
      ready_c = '0;
      if (rst_n && !fifo_full && ((state_q == LOCKED) || found)) ready_c[sel] = 1'b1;
      accept  = |(req_valid & ready_c);
   end

   assign req_ready    = ready_c;
   assign fifo_wen     = accept;
   assign fifo_data_in = req_data[sel];
   assign grant_id     = grant_id_q;
   assign busy         = (state_q == LOCKED);

   // Next-state: lock on any request, release on burst end or owner drop.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      grant_id_d = grant_id_q;
      unique case (state_q)
         IDLE: begin
            if (found) begin
               if (accept && (BURST_MAX == 1)) begin
                  rr_ptr_d = inc_wrap(winner);
               end else begin
                  state_d    = LOCKED;
                  grant_id_d = winner;
                  beat_cnt_d = accept ? CW'(1) : '0;
               end
            end
         end
         LOCKED: begin
            if (!req_valid[grant_id_q] ||
                (accept && (beat_cnt_q == CW'(BURST_MAX - 1)))) begin
               state_d    = IDLE;
               rr_ptr_d   = inc_wrap(grant_id_q);
               beat_cnt_d = '0;
            end else if (accept) begin
               beat_cnt_d = beat_cnt_q + CW'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         rr_ptr_q   <= '0;
         beat_cnt_q <= '0;
         grant_id_q <= '0;
      end else begin
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         beat_cnt_q <= beat_cnt_d;
         grant_id_q <= grant_id_d;
      end
   end

`ifdef SYNC_FIFO_WR_ARB_STATS_EN
   logic [15:0] stat_beats_q [NREQ];
   logic [15:0] stat_beats_d [NREQ];
   logic [15:0] stat_stall_q, stat_stall_d;

   // Saturating statistics counters.
   always_comb begin
      for (int unsigned i = 0; i < NREQ; i++) begin
         stat_beats_d[i] = stat_beats_q[i];
         if (req_valid[IDW'(i)] && ready_c[IDW'(i)] && (stat_beats_q[i] != 16'hFFFF))
            stat_beats_d[i] = stat_beats_q[i] + 16'd1;
      end
      stat_stall_d = stat_stall_q;
      if ((|req_valid) && fifo_full && (stat_stall_q != 16'hFFFF))
         stat_stall_d = stat_stall_q + 16'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREQ; i++) stat_beats_q[i] <= '0;
         stat_stall_q <= '0;
      end else begin
         for (int unsigned i = 0; i < NREQ; i++) stat_beats_q[i] <= stat_beats_d[i];
         stat_stall_q <= stat_stall_d;
      end
   end

   assign stat_beats     = stat_beats_q;
   assign stat_stall_cyc = stat_stall_q;
`endif

endmodule
